bht_ctrl: RTL and testbench
===========================

# bht_ctrl

Branch-history-table controller for the 2-bit saturating predictor: owns an array of 2^INDEX_W two-bit counters and sequences all access to it. It initialises the table after reset or flush, then arbitrates a single table port between a fetch-side predict requester and an execute-side update requester. It sits between the fetch stage, which asks "taken?", and the branch-resolution stage, which reports the outcome.

## Interface
- INDEX_W, 4: table index width; table depth = 2^INDEX_W entries.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous request to re-initialise the whole table.
- pred_valid  in  1  predict request.
- pred_index  in  INDEX_W  entry to read.
- pred_ready  out  1  predict accepted this cycle when pred_valid & pred_ready.
- resp_valid  out  1  registered one-cycle pulse carrying the predict result.
- resp_state  out  2  counter value read.
- resp_taken  out  1  resp_state[1].
- upd_valid  in  1  update request.
- upd_index  in  INDEX_W  entry to update.
- upd_taken  in  1  resolved branch outcome.
- upd_ready  out  1  update accepted when upd_valid & upd_ready.
- busy  out  1  high while the table is being initialised.

## Operation
- Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Counter update: taken → +1, saturating at 11. Not taken → −1, saturating at 00. No wrap in either direction.
- Controller FSM has two states, INIT and RUN.
- INIT:
  - Sweep counter walks index 0 to 2^INDEX_W−1, writing 01 to one entry per cycle.
  - After the last entry is written, the FSM goes to RUN.
  - pred_ready, upd_ready = 0.
  - busy = 1.
- RUN:
  - busy = 0.
  - At most one grant per cycle. The table has a single port.
  - Only one requester valid: it is granted.
  - Both valid: grant follows the priority bit pri (0 = update, 1 = predict), and pri toggles. Pri is unchanged when there is no contention.
  - Ready outputs are combinational from state, flush, the valid inputs and pri. A requester whose valid is low may see ready low.
- Predict grant: entry[pred_index] is registered into resp_state/resp_taken, and resp_valid = 1 in the next cycle.
- Update grant: entry[upd_index] ← saturating update, written at the end of the grant cycle.
- Flush:
  - When flush = 1, no grant is given in that cycle.
  - The next state is INIT with the sweep at 0. This applies in RUN and in INIT; flush during INIT restarts the sweep.
  - A response already registered is still delivered.
- Reset (asynchronous):
  - State = INIT, sweep = 0, pri = 0.
  - resp_valid = 0, resp_state = 00, resp_taken = 0.
  - busy = 1, pred_ready = 0, upd_ready = 0.
  - Table contents are undefined until the sweep has run. Reset during any operation aborts it, and no response is produced for it.

## Timing
- Initialisation takes 2^INDEX_W cycles after reset deassertion (16 for the default). busy falls in the first RUN cycle.
- Predict latency is 1 cycle: request accepted at edge N, response valid from edge N+1 for exactly one cycle.
- A predict read returns the table value before any update granted in a later cycle. An update granted in cycle N is visible to a predict granted in cycle N+1 or later.
- Throughput is one grant per cycle. Under continuous contention the two requesters alternate, so each gets at least one grant every 2 cycles.
- Requesters must hold valid and their payload stable until accepted.

## Structure
- Shared package bht_pkg holds:
  - the counter encodings SNT/WNT/WT/ST as 2-bit localparams;
  - the FSM state encodings INIT/RUN;
  - the init value constant (WNT).
- One sub-module, sat2_next, purely combinational: current 2-bit value plus taken → saturated next value. It is instantiated once on the update write path.
- The table is a flop array inside bht_ctrl. It is not reset per entry; the sweep initialises it.

## Test plan
- Reset, then idle for 16 cycles: busy = 1 for 16 cycles, readies 0, then busy = 0. Predict on each of indices 0–15 returns resp_state = 01, resp_taken = 0.
- Index 3 updated taken ×4: predicts after each update return 10, 11, 11, 11 (saturation). Then not-taken ×4 returns 10, 01, 00, 00.
- pred_valid and upd_valid held high together for 6 cycles: grants go update, predict, update, predict, update, predict; resp_valid pulses on alternate cycles.
- Update index 5 taken in cycle N, predict index 5 in cycle N+1: resp_state = 10, one cycle after the predict grant.
- Flush asserted in RUN with both valids high: no grant that cycle, busy = 1 for 16 cycles, and all entries read 01 afterwards. Flush again at sweep index 7: the sweep restarts and busy lasts 16 more cycles.
- Reset asserted while resp_valid is pending: resp_valid = 0 immediately (asynchronously) and no stale response appears after reset is released.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared definitions for the branch-history-table controller:
// counter encodings, controller states and the table initialisation value.
package bht_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] INIT_VAL = WNT;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bht_ctrl_if.sv
// Fetch/execute-side handshake bundle of the BHT controller.
interface bht_ctrl_if #(
  parameter int INDEX_W = 4
);
  logic               flush;
  logic               pred_valid;
  logic [INDEX_W-1:0] pred_index;
  logic               pred_ready;
  logic               resp_valid;
  logic [1:0]         resp_state;
  logic               resp_taken;
  logic               upd_valid;
  logic [INDEX_W-1:0] upd_index;
  logic               upd_taken;
  logic               upd_ready;
  logic               busy;

  modport master (
    output flush, pred_valid, pred_index, upd_valid, upd_index, upd_taken,
    input  pred_ready, resp_valid, resp_state, resp_taken, upd_ready, busy
  );

  modport slave (
    input  flush, pred_valid, pred_index, upd_valid, upd_index, upd_taken,
    output pred_ready, resp_valid, resp_state, resp_taken, upd_ready, busy
  );
endinterface

// File: rtl/bht_ctrl_sat2_next.sv
// Next value of a 2-bit saturating branch counter given the resolved outcome.
module sat2_next
  import bht_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/bht_ctrl.sv
// BHT controller: sweeps the counter table to WNT after reset/flush, then
// arbitrates its single port between predict reads and update writes.
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int INDEX_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  bht_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << INDEX_W;

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] sweep_reg, sweep_next;
  logic               pri_reg, pri_next;
  logic               resp_valid_reg;
  logic [1:0]         resp_state_reg;
  logic               pred_gnt, upd_gnt;
  logic [1:0]         upd_cur, upd_new;

  logic [1:0] bht_mem [DEPTH];

  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    pri_next   = pri_reg;
    pred_gnt   = 1'b0;
    upd_gnt    = 1'b0;
    if (bus.flush) begin
      state_next = INIT;
      sweep_next = '0;
    end else if (state_reg == INIT) begin
      sweep_next = sweep_reg + 1'b1;
      if (&sweep_reg) state_next = RUN;
    end else if (bus.pred_valid && bus.upd_valid) begin
      // contention: pri picks the winner and flips so the loser goes next
      pred_gnt = pri_reg;
      upd_gnt  = !pri_reg;
      pri_next = !pri_reg;
    end else begin
      pred_gnt = bus.pred_valid;
      upd_gnt  = bus.upd_valid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= INIT;
      sweep_reg      <= '0;
      pri_reg        <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_state_reg <= SNT;
    end else begin
      state_reg      <= state_next;
      sweep_reg      <= sweep_next;
      pri_reg        <= pri_next;
      resp_valid_reg <= pred_gnt;
      if (pred_gnt) resp_state_reg <= bht_mem[bus.pred_index];
    end
  end

  assign upd_cur = bht_mem[bus.upd_index];

  sat2_next u_sat (
    .cur   (upd_cur),
    .taken (bus.upd_taken),
    .nxt   (upd_new)
  );

  // Table contents are deliberately not reset; the sweep defines them.
  always_ff @(posedge clock) begin
    if (state_reg == INIT && !bus.flush) begin
      bht_mem[sweep_reg] <= INIT_VAL;
    end else if (upd_gnt) begin
      bht_mem[bus.upd_index] <= upd_new;
    end
  end

  assign bus.pred_ready = pred_gnt;
  assign bus.upd_ready  = upd_gnt;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_state = resp_state_reg;
  assign bus.resp_taken = resp_state_reg[1];
  assign bus.busy       = (state_reg == INIT);

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl: a table-level reference model checked every
// cycle, plus hand-computed expectations for the documented scenarios.
module tb_bht_ctrl;
  import bht_pkg::*;

  localparam int IW    = 4;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bht_ctrl_if #(.INDEX_W(IW)) bus ();
  bht_ctrl #(.INDEX_W(IW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input bit loud);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end else if (loud) begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Reference model: remaining init cycles, arbitration bit, table contents.
  int         init_left;
  bit         m_pri;
  logic [1:0] m_tbl [DEPTH];
  bit         exp_rv;
  logic [1:0] exp_rs;

  function automatic void grants(output bit pg, output bit ug);
    pg = 0;
    ug = 0;
    if (init_left == 0 && bus.flush !== 1'b1) begin
      if (bus.pred_valid === 1'b1 && bus.upd_valid === 1'b1) begin
        pg = m_pri;
        ug = !m_pri;
      end else begin
        pg = (bus.pred_valid === 1'b1);
        ug = (bus.upd_valid === 1'b1);
      end
    end
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] v, input logic t);
    int n;
    n = t ? int'(v) + 1 : int'(v) - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return n[1:0];
  endfunction

  always @(posedge clock or posedge reset) begin
    bit pg, ug;
    if (reset) begin
      init_left = DEPTH;
      m_pri     = 0;
      exp_rv    = 0;
      exp_rs    = 2'b00;
    end else begin
      grants(pg, ug);
      exp_rv = pg;
      if (pg) exp_rs = m_tbl[bus.pred_index];
      if (ug) m_tbl[bus.upd_index] = sat(m_tbl[bus.upd_index], bus.upd_taken);
      if (pg && ug) $display("FAIL model_double_grant: got 2 want 1");
      if (init_left == 0 && bus.flush !== 1'b1 && bus.pred_valid === 1'b1 && bus.upd_valid === 1'b1)
        m_pri = !m_pri;
      if (bus.flush === 1'b1) begin
        init_left = DEPTH;
      end else if (init_left > 0) begin
        init_left--;
        if (init_left == 0) foreach (m_tbl[i]) m_tbl[i] = WNT;
      end
    end
  end

  always @(negedge clock) begin
    bit pg, ug;
    #1;
    grants(pg, ug);
    chk("busy",       bus.busy,       init_left > 0, 0);
    chk("pred_ready", bus.pred_ready, pg, 0);
    chk("upd_ready",  bus.upd_ready,  ug, 0);
    chk("resp_valid", bus.resp_valid, exp_rv, 0);
    chk("resp_state", bus.resp_state, exp_rs, 0);
    chk("resp_taken", bus.resp_taken, exp_rs[1], 0);
  end

  task automatic count_busy(output int n);
    n = 0;
    #2;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      @(negedge clock);
      #2;
    end
  endtask

  task automatic do_pred(input int idx, input logic [1:0] exp, input bit now);
    if (!now) @(negedge clock);
    bus.pred_valid = 1'b1;
    bus.pred_index = idx[IW-1:0];
    #1;
    chk($sformatf("pred_ready[%0d]", idx), bus.pred_ready, 1, 1);
    @(negedge clock);
    bus.pred_valid = 1'b0;
    #1;
    chk($sformatf("resp_valid[%0d]", idx), bus.resp_valid, 1, 1);
    chk($sformatf("resp_state[%0d]", idx), bus.resp_state, exp, 1);
    chk($sformatf("resp_taken[%0d]", idx), bus.resp_taken, exp[1], 1);
  endtask

  task automatic do_upd(input int idx, input bit taken);
    @(negedge clock);
    bus.upd_valid = 1'b1;
    bus.upd_index = idx[IW-1:0];
    bus.upd_taken = taken;
    #1;
    chk($sformatf("upd_ready[%0d]", idx), bus.upd_ready, 1, 1);
    @(negedge clock);
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [1:0] seq3 [8];
    seq3 = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    bus.flush = 0; bus.pred_valid = 0; bus.pred_index = 0;
    bus.upd_valid = 0; bus.upd_index = 0; bus.upd_taken = 0;

    #1 reset = 1'b1;
    #1;
    chk("reset_busy", bus.busy, 1, 1);
    chk("reset_resp_valid", bus.resp_valid, 0, 1);
    chk("reset_resp_state", bus.resp_state, 0, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    count_busy(n);
    chk("init_busy_cycles", n, 16, 1);

    for (int i = 0; i < DEPTH; i++) do_pred(i, 2'b01, 0);

    for (int i = 0; i < 8; i++) begin
      do_upd(3, i < 4);
      do_pred(3, seq3[i], 0);
    end

    do_upd(5, 1);
    do_pred(5, 2'b10, 1);

    // Sustained contention on entry 9: update wins first, then alternate.
    @(negedge clock);
    bus.pred_valid = 1; bus.pred_index = 9;
    bus.upd_valid = 1; bus.upd_index = 9; bus.upd_taken = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("cont_pred_ready[%0d]", c), bus.pred_ready, c % 2, 1);
      chk($sformatf("cont_upd_ready[%0d]", c), bus.upd_ready, (c + 1) % 2, 1);
      @(negedge clock);
    end
    bus.pred_valid = 0; bus.upd_valid = 0;
    #1;
    chk("cont_last_resp_state", bus.resp_state, 2'b11, 1);
    do_pred(9, 2'b11, 0);

    // Flush in RUN with both requesters asking.
    @(negedge clock);
    bus.flush = 1; bus.pred_valid = 1; bus.pred_index = 3;
    bus.upd_valid = 1; bus.upd_index = 4; bus.upd_taken = 1;
    #1;
    chk("flush_pred_ready", bus.pred_ready, 0, 1);
    chk("flush_upd_ready", bus.upd_ready, 0, 1);
    @(negedge clock);
    bus.flush = 0; bus.pred_valid = 0; bus.upd_valid = 0;
    count_busy(n);
    chk("flush_busy_cycles", n, 16, 1);
    for (int i = 0; i < DEPTH; i++) do_pred(i, 2'b01, 0);

    // Second flush lands while the sweep is at index 7.
    @(negedge clock);
    bus.flush = 1;
    @(negedge clock);
    bus.flush = 0;
    repeat (7) @(negedge clock);
    #1;
    chk("sweep7_busy", bus.busy, 1, 1);
    bus.flush = 1;
    @(negedge clock);
    bus.flush = 0;
    count_busy(n);
    chk("restart_busy_cycles", n, 16, 1);

    // Reset while a response is on the wire.
    do_upd(3, 1);
    @(negedge clock);
    bus.pred_valid = 1; bus.pred_index = 3;
    @(posedge clock);
    #1;
    chk("pre_reset_resp_valid", bus.resp_valid, 1, 1);
    #1;
    bus.pred_valid = 0;
    reset = 1'b1;
    #1;
    chk("async_reset_resp_valid", bus.resp_valid, 0, 1);
    chk("async_reset_busy", bus.busy, 1, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    count_busy(n);
    chk("post_reset_busy_cycles", n, 16, 1);
    do_pred(3, 2'b01, 0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
